// File: rtl/pcecd_phase_sequencer.sv
// Target-side bus phase sequencer: collects a command over REQ/ACK, holds it for an
// executor, then returns the status and message bytes before releasing the bus.
module pcecd_phase_sequencer #(
    parameter int CMD_MAX = 12
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sel,
    input  logic       i_ack,
    input  logic       i_bus_rst,
    input  logic [7:0] i_db,
    output logic [7:0] o_db,
    output logic       o_bsy,
    output logic       o_req,
    output logic       o_msg,
    output logic       o_cd,
    output logic       o_io,
    output logic [2:0] o_phase,
    output logic       o_cmd_valid,
    output logic [4:0] o_cmd_len,
    input  logic [3:0] i_cmd_rd_addr,
    output logic [7:0] o_cmd_rd_data,
    input  logic       i_done,
    input  logic [7:0] i_status,
    input  logic [7:0] i_message,
    output logic       o_irq_done,
    output logic       o_rst_seen
);

    typedef enum logic [2:0] {
        BUS_FREE   = 3'd0,
        COMMAND    = 3'd1,
        EXECUTE    = 3'd2,
        STATUS     = 3'd3,
        MESSAGE_IN = 3'd4
    } state_t;

    state_t     state_reg;
    logic [3:0] sig_reg;            // {bsy, msg, cd, io}
    logic       req_reg;
    logic [7:0] db_reg;
    logic [7:0] msg_latch_reg;
    logic [4:0] count_reg;
    logic       cmd_valid_reg;
    logic       irq_done_reg;
    logic       rst_seen_reg;
    logic       bus_rst_d_reg;

    logic                   bus_rst_edge;
    logic                   buf_we;
    logic [4:0]             req_len;
    logic [CMD_MAX*8-1:0]   cmd_flat;
    logic [7:0]             rd_data;

    function automatic logic [3:0] phase_bits(input state_t s);
        case (s)
            COMMAND:    return 4'b1010;
            EXECUTE:    return 4'b1000;
            STATUS:     return 4'b1011;
            MESSAGE_IN: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    assign bus_rst_edge = i_bus_rst & ~bus_rst_d_reg;

    // Bytes past CMD_MAX are acknowledged but dropped.
    assign buf_we = !i_rst && !bus_rst_edge && (state_reg == COMMAND) && req_reg && i_ack
                    && (count_reg < 5'(CMD_MAX));

    genvar gi;
    generate
        for (gi = 0; gi < CMD_MAX; gi++) begin : g_cmd_buf
            logic [7:0] entry_reg;
            always_ff @(posedge i_clk) begin
                if (buf_we && count_reg == 5'(gi)) begin
                    entry_reg <= i_db;
                end
            end
            assign cmd_flat[gi*8 +: 8] = entry_reg;
        end
    endgenerate

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < CMD_MAX; i++) begin
            if (i_cmd_rd_addr == 4'(i)) begin
                rd_data = cmd_flat[i*8 +: 8];
            end
        end
    end

    // Command group in opcode bits [7:5] selects the CDB length.
    always_comb begin
        case (cmd_flat[7:5])
            3'd0, 3'd3, 3'd4: req_len = 5'd6;
            3'd5:             req_len = (CMD_MAX < 12) ? 5'(CMD_MAX) : 5'd12;
            default:          req_len = 5'd10;
        endcase
    end

    always_ff @(posedge i_clk) begin
        bus_rst_d_reg <= i_bus_rst;
        irq_done_reg  <= 1'b0;
        rst_seen_reg  <= 1'b0;
        if (i_rst) begin
            state_reg     <= BUS_FREE;
            sig_reg       <= 4'b0000;
            req_reg       <= 1'b0;
            db_reg        <= 8'h00;
            msg_latch_reg <= 8'h00;
            count_reg     <= 5'd0;
            cmd_valid_reg <= 1'b0;
            bus_rst_d_reg <= 1'b0;
        end else if (bus_rst_edge) begin
            state_reg     <= BUS_FREE;
            sig_reg       <= 4'b0000;
            req_reg       <= 1'b0;
            db_reg        <= 8'h00;
            count_reg     <= 5'd0;
            cmd_valid_reg <= 1'b0;
            rst_seen_reg  <= 1'b1;
        end else begin
            case (state_reg)
                BUS_FREE: begin
                    if (i_sel && !i_bus_rst) begin
                        state_reg <= COMMAND;
                        sig_reg   <= phase_bits(COMMAND);
                        req_reg   <= 1'b1;
                        count_reg <= 5'd0;
                    end
                end
                COMMAND: begin
                    if (req_reg) begin
                        if (i_ack) begin
                            req_reg <= 1'b0;
                            if (count_reg < 5'(CMD_MAX)) begin
                                count_reg <= count_reg + 5'd1;
                            end
                        end
                    end else if (!i_ack) begin
                        if (count_reg == req_len) begin
                            state_reg     <= EXECUTE;
                            sig_reg       <= phase_bits(EXECUTE);
                            cmd_valid_reg <= 1'b1;
                        end else begin
                            req_reg <= 1'b1;
                        end
                    end
                end
                EXECUTE: begin
                    if (i_done) begin
                        state_reg     <= STATUS;
                        sig_reg       <= phase_bits(STATUS);
                        db_reg        <= i_status;
                        req_reg       <= 1'b1;
                        msg_latch_reg <= i_message;
                        cmd_valid_reg <= 1'b0;
                    end
                end
                STATUS: begin
                    if (req_reg) begin
                        if (i_ack) begin
                            req_reg <= 1'b0;
                        end
                    end else if (!i_ack) begin
                        state_reg <= MESSAGE_IN;
                        sig_reg   <= phase_bits(MESSAGE_IN);
                        db_reg    <= msg_latch_reg;
                        req_reg   <= 1'b1;
                    end
                end
                MESSAGE_IN: begin
                    if (req_reg) begin
                        if (i_ack) begin
                            req_reg <= 1'b0;
                        end
                    end else if (!i_ack) begin
                        state_reg    <= BUS_FREE;
                        sig_reg      <= 4'b0000;
                        db_reg       <= 8'h00;
                        irq_done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= BUS_FREE;
                    sig_reg       <= 4'b0000;
                    req_reg       <= 1'b0;
                    db_reg        <= 8'h00;
                    cmd_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign o_phase       = state_reg;
    assign o_bsy         = sig_reg[3];
    assign o_msg         = sig_reg[2];
    assign o_cd          = sig_reg[1];
    assign o_io          = sig_reg[0];
    assign o_req         = req_reg;
    assign o_db          = db_reg;
    assign o_cmd_valid   = cmd_valid_reg;
    assign o_cmd_len     = count_reg;
    assign o_cmd_rd_data = rd_data;
    assign o_irq_done    = irq_done_reg;
    assign o_rst_seen    = rst_seen_reg;

endmodule
